// File: rtl/al_logic_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | al_logic_mac: pipelined multiply-accumulate with valid tags, global ce,  |
// | load/accumulate control and overflow detect/saturate.   Revision 1.0     |
// +--------------------------------------------------------------------------+
module al_logic_mac #(
  parameter int    INPUT_WIDTH_A = 18,
  parameter int    INPUT_WIDTH_B = 18,
  parameter int    ACC_WIDTH     = 48,
  parameter string INPUTFORMAT   = "SIGNED",
  parameter int    PIPE_STAGES   = 2,
  parameter string SATURATE      = "DISABLE"
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     ce,
  input  logic                     in_valid,
  input  logic [INPUT_WIDTH_A-1:0] a,
  input  logic [INPUT_WIDTH_B-1:0] b,
  input  logic                     acc_en,
  input  logic                     acc_clr,
  output logic                     out_valid,
  output logic [ACC_WIDTH-1:0]     p,
  output logic                     ovf
);

  localparam int PROD_W    = INPUT_WIDTH_A + INPUT_WIDTH_B;
  localparam int LAST      = PIPE_STAGES - 1;
  localparam bit IS_SIGNED = (INPUTFORMAT == "SIGNED");
  localparam bit DO_SAT    = (SATURATE == "ENABLE");
  localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [INPUT_WIDTH_A-1:0] a_q, a_d;
  logic [INPUT_WIDTH_B-1:0] b_q, b_d;
  logic                     en_q, en_d, clr_q, clr_d, vld_q, vld_d;

  logic [PROD_W-1:0]        prod_q [PIPE_STAGES];
  logic [PROD_W-1:0]        prod_d [PIPE_STAGES];
  logic [PROD_W-1:0]        prod_src [PIPE_STAGES];
  logic [PIPE_STAGES-1:0]   pen_q, pen_d, pen_src;
  logic [PIPE_STAGES-1:0]   pclr_q, pclr_d, pclr_src;
  logic [PIPE_STAGES-1:0]   pvld_q, pvld_d, pvld_src;

  logic [ACC_WIDTH-1:0]     acc_q, acc_d;
  logic                     ovf_q, ovf_d, out_valid_q, out_valid_d;

  logic [PROD_W-1:0]        mult;
  logic [ACC_WIDTH-1:0]     prod_ext, sum, sat_val;
  logic                     add_ovf;

  generate
    if (IS_SIGNED) begin : g_signed
      assign mult     = PROD_W'($signed(a_q)) * PROD_W'($signed(b_q));
      assign prod_ext = ACC_WIDTH'($signed(prod_q[LAST]));
      assign sum      = acc_q + prod_ext;
      // Two same-signed addends yielding an opposite-signed result.
      assign add_ovf  = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                        (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
      assign sat_val  = acc_q[ACC_WIDTH-1] ? SMIN : SMAX;
    end else begin : g_unsigned
      logic carry;
      assign mult          = PROD_W'(a_q) * PROD_W'(b_q);
      assign prod_ext      = ACC_WIDTH'(prod_q[LAST]);
      assign {carry, sum}  = {1'b0, acc_q} + {1'b0, prod_ext};
      assign add_ovf       = carry;
      assign sat_val       = '1;
    end
  endgenerate

  // Stage i of the product pipe is fed by stage i-1, stage 0 by the multiplier.
  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_pipe
    if (i == 0) begin : g_head
      assign prod_src[i] = mult;
      assign pen_src[i]  = en_q;
      assign pclr_src[i] = clr_q;
      assign pvld_src[i] = vld_q;
    end else begin : g_tail
      assign prod_src[i] = prod_q[i-1];
      assign pen_src[i]  = pen_q[i-1];
      assign pclr_src[i] = pclr_q[i-1];
      assign pvld_src[i] = pvld_q[i-1];
    end
  end

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    en_d        = en_q;
    clr_d       = clr_q;
    vld_d       = vld_q;
    prod_d      = prod_q;
    pen_d       = pen_q;
    pclr_d      = pclr_q;
    pvld_d      = pvld_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    if (ce) begin
      a_d         = a;
      b_d         = b;
      en_d        = acc_en;
      clr_d       = acc_clr;
      vld_d       = in_valid;
      prod_d      = prod_src;
      pen_d       = pen_src;
      pclr_d      = pclr_src;
      pvld_d      = pvld_src;
      out_valid_d = pvld_q[LAST];
      if (pvld_q[LAST]) begin
        if (pclr_q[LAST] || !pen_q[LAST]) begin
          acc_d = prod_ext;
          ovf_d = 1'b0;
        end else if (add_ovf) begin
          acc_d = DO_SAT ? sat_val : sum;
          ovf_d = 1'b1;
        end else begin
          acc_d = sum;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      a_q         <= '0;
      b_q         <= '0;
      en_q        <= 1'b0;
      clr_q       <= 1'b0;
      vld_q       <= 1'b0;
      prod_q      <= '{default: '0};
      pen_q       <= '0;
      pclr_q      <= '0;
      pvld_q      <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      en_q        <= en_d;
      clr_q       <= clr_d;
      vld_q       <= vld_d;
      prod_q      <= prod_d;
      pen_q       <= pen_d;
      pclr_q      <= pclr_d;
      pvld_q      <= pvld_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign p         = acc_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_al_logic_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_al_logic_mac: five MAC configurations driven in parallel, checked     |
// | against an arithmetic reference model via per-DUT queues. Revision 1.0   |
// +--------------------------------------------------------------------------+
module tb_al_logic_mac;

  localparam int NDUT = 5;
  localparam int ACCW [NDUT] = '{48, 36, 36, 36, 40};
  localparam bit SGN  [NDUT] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam bit SAT  [NDUT] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam int PS   [NDUT] = '{2, 2, 2, 1, 4};

  typedef struct {
    longint      due;
    logic [63:0] p;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn, ce, in_valid, acc_en, acc_clr;
  logic [17:0] a, b;
  logic [47:0] p0;
  logic [35:0] p1, p2, p3;
  logic [39:0] p4;
  logic [NDUT-1:0] vld, ov;
  logic [63:0] pv [NDUT];

  exp_t        sb [NDUT][$];
  longint      m_acc [NDUT];
  logic        m_ovf [NDUT];
  longint      ecnt = 0;
  int          edge_kind = 0;   // 0 none yet, 1 reset, 2 ce edge, 3 stalled edge
  int          checks = 0;
  int          errors = 0;
  logic        hv [NDUT];
  logic [63:0] hp [NDUT];
  logic        ho [NDUT];

  always #5 clk = ~clk;

  al_logic_mac u_d0 (.clk(clk), .rstn(rstn), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
                     .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(vld[0]), .p(p0), .ovf(ov[0]));
  al_logic_mac #(.ACC_WIDTH(36), .SATURATE("ENABLE")) u_d1 (
                     .clk(clk), .rstn(rstn), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
                     .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(vld[1]), .p(p1), .ovf(ov[1]));
  al_logic_mac #(.ACC_WIDTH(36), .SATURATE("DISABLE")) u_d2 (
                     .clk(clk), .rstn(rstn), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
                     .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(vld[2]), .p(p2), .ovf(ov[2]));
  al_logic_mac #(.ACC_WIDTH(36), .INPUTFORMAT("UNSIGNED"), .PIPE_STAGES(1), .SATURATE("ENABLE")) u_d3 (
                     .clk(clk), .rstn(rstn), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
                     .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(vld[3]), .p(p3), .ovf(ov[3]));
  al_logic_mac #(.ACC_WIDTH(40), .PIPE_STAGES(4)) u_d4 (
                     .clk(clk), .rstn(rstn), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
                     .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(vld[4]), .p(p4), .ovf(ov[4]));

  assign pv[0] = 64'(p0);
  assign pv[1] = 64'(p1);
  assign pv[2] = 64'(p2);
  assign pv[3] = 64'(p3);
  assign pv[4] = 64'(p4);

  // Reference: exact integer arithmetic, then range check against the accumulator width.
  function automatic void model_push(int d, longint cnt);
    longint span, hi, lo, va, vb, pr, s;
    exp_t   e;
    span = longint'(1) << ACCW[d];
    if (SGN[d]) begin
      va = longint'($signed(a));
      vb = longint'($signed(b));
      lo = -(span / 2);
      hi = span / 2 - 1;
    end else begin
      va = longint'(a);
      vb = longint'(b);
      lo = 0;
      hi = span - 1;
    end
    pr = va * vb;
    if (acc_clr || !acc_en) begin
      m_acc[d] = pr;
      m_ovf[d] = 1'b0;
    end else begin
      s = m_acc[d] + pr;
      if (s > hi || s < lo) begin
        m_ovf[d] = 1'b1;
        if (SAT[d]) s = (s > hi) ? hi : lo;
        else        s = (s > hi) ? s - span : s + span;
      end
      m_acc[d] = s;
    end
    e.due = cnt + PS[d] + 1;
    e.p   = m_acc[d] & 64'(span - 1);
    e.ovf = m_ovf[d];
    sb[d].push_back(e);
  endfunction

  // Input side: model accepted samples at each clock edge.
  initial begin
    for (int d = 0; d < NDUT; d++) begin
      m_acc[d] = 0;
      m_ovf[d] = 1'b0;
    end
    forever begin
      @(posedge clk);
      if (!rstn) begin
        for (int d = 0; d < NDUT; d++) begin
          sb[d].delete();
          m_acc[d] = 0;
          m_ovf[d] = 1'b0;
        end
        edge_kind = 1;
      end else if (ce) begin
        ecnt++;
        if (in_valid)
          for (int d = 0; d < NDUT; d++) model_push(d, ecnt);
        edge_kind = 2;
      end else begin
        edge_kind = 3;
      end
    end
  end

  // Output side: every cycle, compare all outputs against the expected state.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (edge_kind != 0) begin
        for (int d = 0; d < NDUT; d++) begin
          if (edge_kind == 1) begin
            hv[d] = 1'b0;
            hp[d] = '0;
            ho[d] = 1'b0;
          end else if (edge_kind == 2) begin
            if (sb[d].size() > 0 && sb[d][0].due == ecnt) begin
              e     = sb[d].pop_front();
              hv[d] = 1'b1;
              hp[d] = e.p;
              ho[d] = e.ovf;
            end else begin
              hv[d] = 1'b0;
            end
          end
          checks++;
          if (vld[d] !== hv[d] || pv[d] !== hp[d] || ov[d] !== ho[d]) begin
            errors++;
            $display("FAIL dut%0d edge %0d: out_valid/p/ovf = %0b/%h/%0b, expected %0b/%h/%0b",
                     d, ecnt, vld[d], pv[d], ov[d], hv[d], hp[d], ho[d]);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [17:0] aa, input logic [17:0] bb,
                       input logic en, input logic clr);
    in_valid = v;
    a        = aa;
    b        = bb;
    acc_en   = en;
    acc_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 18'd0, 18'd0, 1'b0, 1'b0);
  endtask

  function automatic logic [17:0] pick();
    case ($urandom_range(0, 3))
      0:       return 18'($urandom);
      1:       return 18'h20000;
      2:       return 18'h1FFFF;
      default: return 18'h3FFFF;
    endcase
  endfunction

  initial begin
    rstn = 1'b0; ce = 1'b1; in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 64'(vld[0]), 64'd0);
    chk("reset_p", pv[0], 64'd0);
    rstn = 1'b1;

    // Single signed multiply, latency 4 on the default configuration.
    drive(1'b1, 18'd3, 18'(-5), 1'b0, 1'b0);
    idle(3);
    chk("mul_valid", 64'(vld[0]), 64'd1);
    chk("mul_p", pv[0], 64'hFFFF_FFFF_FFF1);
    chk("mul_ovf", 64'(ov[0]), 64'd0);
    idle(1);
    chk("mul_valid_drop", 64'(vld[0]), 64'd0);

    // Back-to-back stream with load/accumulate control.
    drive(1'b1, 18'd2, 18'd3, 1'b0, 1'b1);
    drive(1'b1, 18'd4, 18'd5, 1'b1, 1'b0);
    drive(1'b1, 18'(-1), 18'd7, 1'b1, 1'b0);
    drive(1'b1, 18'd6, 18'd6, 1'b0, 1'b1);
    begin
      logic [63:0] exp_s [4];
      exp_s = '{64'd6, 64'd26, 64'd19, 64'd36};
      for (int i = 0; i < 4; i++) begin
        chk("stream_p", pv[0], exp_s[i]);
        chk("stream_valid", 64'(vld[0]), 64'd1);
        idle(1);
      end
    end
    idle(4);

    // Stall with in_valid held high, then a bubble.
    drive(1'b1, 18'd5, 18'd6, 1'b0, 1'b1);
    drive(1'b1, 18'd7, 18'(-2), 1'b1, 1'b0);
    ce = 1'b0;
    repeat (3) drive(1'b1, 18'd100, 18'd100, 1'b1, 1'b0);
    ce = 1'b1;
    drive(1'b0, 18'd0, 18'd0, 1'b0, 1'b0);
    drive(1'b1, 18'd9, 18'd9, 1'b1, 1'b0);
    drive(1'b1, 18'(-3), 18'd4, 1'b1, 1'b0);
    idle(6);

    // Saturation (dut1) versus wrap (dut2) at 36-bit accumulator width.
    drive(1'b1, 18'h20000, 18'h20000, 1'b0, 1'b1);
    drive(1'b1, 18'h20000, 18'h20000, 1'b1, 1'b0);
    drive(1'b1, 18'h20000, 18'h20000, 1'b1, 1'b0);
    drive(1'b1, 18'h20000, 18'h20000, 1'b1, 1'b0);
    chk("sat_first", pv[1], 64'h4_0000_0000);
    drive(1'b1, 18'd1, 18'd1, 1'b0, 1'b1);
    chk("sat_clamp_p", pv[1], 64'd34359738367);
    chk("sat_clamp_ovf", 64'(ov[1]), 64'd1);
    chk("wrap_p", pv[2], 64'h8_0000_0000);
    chk("wrap_ovf", 64'(ov[2]), 64'd1);
    idle(1);
    chk("sat_hold1", pv[1], 64'd34359738367);
    idle(1);
    chk("sat_hold2", pv[1], 64'd34359738367);
    idle(1);
    chk("sat_reload_p", pv[1], 64'd1);
    chk("sat_reload_ovf", 64'(ov[1]), 64'd0);
    idle(4);

    // Unsigned full-scale product on the 1-stage pipe; latency of the 4-stage pipe.
    drive(1'b1, 18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0);
    idle(1);
    chk("lat3_early", 64'(vld[3]), 64'd0);
    idle(1);
    chk("lat3_valid", 64'(vld[3]), 64'd1);
    chk("unsigned_p", pv[3], 64'd68718952449);
    idle(2);
    chk("lat6_early", 64'(vld[4]), 64'd0);
    idle(1);
    chk("lat6_valid", 64'(vld[4]), 64'd1);
    chk("lat6_p", pv[4], 64'd1);
    idle(4);

    // Reset with samples in flight.
    drive(1'b1, 18'd2, 18'd3, 1'b0, 1'b1);
    drive(1'b1, 18'd3, 18'd4, 1'b1, 1'b0);
    drive(1'b1, 18'd5, 18'd6, 1'b1, 1'b0);
    rstn = 1'b0;
    drive(1'b1, 18'd9, 18'd9, 1'b0, 1'b1);
    chk("rst_valid", 64'(vld[0]), 64'd0);
    chk("rst_p", pv[0], 64'd0);
    chk("rst_ovf", 64'(ov[0]), 64'd0);
    rstn = 1'b1;
    drive(1'b1, 18'd7, 18'd7, 1'b0, 1'b1);
    idle(2);
    chk("rst_lat_early", 64'(vld[0]), 64'd0);
    idle(1);
    chk("rst_lat_valid", 64'(vld[0]), 64'd1);
    chk("rst_lat_p", pv[0], 64'd49);
    idle(4);

    // Randomised traffic: stalls, bubbles, occasional resets, extreme operands.
    for (int i = 0; i < 3000; i++) begin
      ce   = ($urandom_range(0, 99) < 85);
      rstn = ($urandom_range(0, 299) != 0);
      drive(($urandom_range(0, 99) < 80), pick(), pick(),
            ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 10));
    end
    rstn = 1'b1;
    ce   = 1'b1;
    idle(10);
    for (int d = 0; d < NDUT; d++) chk("drain", 64'(sb[d].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/al_logic_mac.md
Name:
al_logic_mac

Overview:
- Parametrised pipelined multiply-accumulate unit; next generation of the soft multiplier primitive in the simulation/gate library.
- Adds:
  - configurable product pipeline depth;
  - a valid-tagged streaming interface with global clock enable;
  - per-sample load/accumulate control;
  - overflow detection with optional saturation.
- Sits in the DSP datapath (filters, dot products) where a bare multiplier needs a following adder and control FSM.

Parameters:
- INPUT_WIDTH_A, 18, operand a width (2..32)
- INPUT_WIDTH_B, 18, operand b width (2..32)
- ACC_WIDTH, 48, accumulator/output width; must be >= INPUT_WIDTH_A+INPUT_WIDTH_B
- INPUTFORMAT, "SIGNED", "SIGNED" or "UNSIGNED" for both operands and accumulator
- PIPE_STAGES, 2, product register stages between input regs and accumulator (1..4)
- SATURATE, "DISABLE", "ENABLE" clamps accumulator on overflow; "DISABLE" wraps

Ports:
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  synchronous active-low reset
- ce  in  1  global clock enable; 0 freezes every register including valid/tag pipeline
- in_valid  in  1  a/b/acc_en/acc_clr valid this cycle (sampled when ce=1)
- a  in  INPUT_WIDTH_A  operand a
- b  in  INPUT_WIDTH_B  operand b
- acc_en  in  1  1: add product to accumulator; 0: load product (plain multiply)
- acc_clr  in  1  1: start new accumulation (load product), overrides acc_en
- out_valid  out  1  p/ovf hold a new result this cycle
- p  out  ACC_WIDTH  accumulator value
- ovf  out  1  sticky overflow flag for current accumulation

Behaviour:
- Reset (rstn=0 at clk edge, regardless of ce):
  - every register cleared: out_valid=0, p=0, ovf=0;
  - all valid tags cleared, so in-flight samples are discarded.
- Pipeline: stage 0 input regs (a, b, acc_en, acc_clr, valid) -> PIPE_STAGES product regs -> accumulator reg.
- Latency L = PIPE_STAGES+2 cycles with ce held 1; default L=4.
- Throughput: one sample per cycle.
- Data regs load only when ce=1. Valid tag: stage 0 takes in_valid; each stage copies the previous stage's tag.
- Product: full INPUT_WIDTH_A+INPUT_WIDTH_B bit product, sign-extended (SIGNED) or zero-extended (UNSIGNED) to ACC_WIDTH.
- Accumulator stage, on ce=1 with valid tag set:
  - load (acc_clr=1 or acc_en=0): p=product, ovf=0.
  - add (acc_en=1, acc_clr=0): p=p+product.
    - SIGNED overflow: operand signs equal and result sign differs.
    - UNSIGNED overflow: carry out of ACC_WIDTH.
    - On overflow, ovf set and stays set until next load.
    - SATURATE="ENABLE": p clamps to the limit in the overflow direction (SIGNED 2^(ACC_WIDTH-1)-1 / -2^(ACC_WIDTH-1); UNSIGNED 2^ACC_WIDTH-1). Once saturated, further same-direction adds hold the limit; opposite-direction adds resume from it.
    - SATURATE="DISABLE": p wraps modulo 2^ACC_WIDTH.
- out_valid: 1 for exactly one ce=1 cycle per accepted sample, coincident with the new p.
- Without a valid tag (bubble): p and ovf hold.
- ce=0: out_valid, p, ovf hold their values (out_valid may remain 1 across stall cycles).
- in_valid=0 inserts a bubble; the accumulator is unaffected.
- First sample after reset with acc_en=1, acc_clr=0 adds to 0 (legal).
- Reset during an accumulation: partial sum lost; first valid sample after release appears L cycles later.
- rstn=0 together with in_valid=1: sample dropped.

Test Plan:
- Defaults, SIGNED: a=3, b=-5, acc_en=0 at cycle t -> out_valid=1 at t+4, p=-15 (0xFFFFFFFFFFF1), ovf=0; out_valid=0 at t+5.
- Back-to-back stream (2,3,clr=1), (4,5,acc_en=1), (-1,7,acc_en=1), then (6,6,clr=1) -> p=6, 26, 19, 36 on four consecutive cycles, out_valid continuously 1.
- ce=0 for 3 cycles mid-stream with in_valid=1 and bubble (in_valid=0) inserted -> sequence unchanged; no duplicated or dropped results; p/out_valid frozen during stall; bubble produces out_valid=0.
- ACC_WIDTH=36, SATURATE="ENABLE", a=b=-131072 with clr then acc_en x3:
  - p=2^34, then 34359738367 with ovf=1, then held at 34359738367;
  - next clr sample 1x1 -> p=1, ovf=0.
  - Repeat with SATURATE="DISABLE": second result p=-2^35, ovf=1.
- UNSIGNED, a=b=262143, acc_en=0 -> p=68718952449; PIPE_STAGES=1 and 4 sweeps -> latency 3 and 6.
- rstn=0 one cycle while 3 samples in flight -> no out_valid for those samples, p=0, ovf=0 next cycle; a new sample after release appears exactly L cycles later.
